// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_if : imem, hazard-unit and Decode signals of the fetch stage |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               stall_F;
  logic               flush_F;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_D;
  logic [ADDR_W-1:0]  pc_D;
  logic               valid_D;

  modport master (
    input  stall_F, flush_F, branch_taken, branch_target, imem_rdata,
    output imem_addr, imem_rd_en, instr_D, pc_D, valid_D
  );

  modport slave (
    output stall_F, flush_F, branch_taken, branch_target, imem_rdata,
    input  imem_addr, imem_rd_en, instr_D, pc_D, valid_D
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : instruction fetch + FD register with 1-entry skid buffer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]        HLT_OP   = 5'h1F
) (
  input  wire logic     clk,
  input  wire logic     rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] instr_D_q, instr_D_d;
  logic [ADDR_W-1:0]  pc_D_q, pc_D_d;
  logic               valid_D_q, valid_D_d;
  logic               issue;
  logic               redirect;

  assign redirect = bus.branch_taken | bus.flush_F;
  // HOLD with stall released re-issues in the same cycle it drains the skid
  assign issue    = !rst && !bus.stall_F && !redirect && (state_q != ST_HALT);

  assign bus.imem_addr  = fetch_pc_q;
  assign bus.imem_rd_en = issue;
  assign bus.instr_D    = instr_D_q;
  assign bus.pc_D       = pc_D_q;
  assign bus.valid_D    = valid_D_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = 1'b0;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    instr_D_d    = instr_D_q;
    pc_D_d       = pc_D_q;
    valid_D_d    = valid_D_q;

    if (issue) begin
      req_pc_d    = fetch_pc_q;
      req_valid_d = 1'b1;
      fetch_pc_d  = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    unique case (state_q)
      ST_RUN: begin
        if (bus.stall_F) begin
          if (req_valid_q) begin
            skid_d       = bus.imem_rdata;
            skid_pc_d    = req_pc_q;
            skid_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end else begin
          instr_D_d = bus.imem_rdata;
          pc_D_d    = req_pc_q;
          valid_D_d = req_valid_q;
          if (req_valid_q && (bus.imem_rdata[INSTR_W-1 -: 5] == HLT_OP)) begin
            state_d     = ST_HALT;
            req_valid_d = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (!bus.stall_F) begin
          instr_D_d    = skid_q;
          pc_D_d       = skid_pc_q;
          valid_D_d    = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = ST_RUN;
          if (skid_q[INSTR_W-1 -: 5] == HLT_OP) begin
            state_d     = ST_HALT;
            req_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Redirect/flush overrides the stall outcome computed above
    if (redirect) begin
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if (bus.flush_F) begin
        valid_D_d = 1'b0;
      end
      if (bus.branch_taken) begin
        fetch_pc_d = bus.branch_target;
        state_d    = ST_RUN;
      end else begin
        state_d = (state_q == ST_HALT) ? ST_HALT : ST_RUN;
        if (skid_valid_q) begin
          fetch_pc_d = skid_pc_q;
        end else if (req_valid_q) begin
          fetch_pc_d = req_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      instr_D_q    <= '0;
      pc_D_q       <= '0;
      valid_D_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      instr_D_q    <= instr_D_d;
      pc_D_q       <= pc_D_d;
      valid_D_q    <= valid_D_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : directed tests for fetch_stage (two instances: PC 0/FE) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  fetch_stage_if #(.ADDR_W(8), .INSTR_W(16)) bus_a ();
  fetch_stage_if #(.ADDR_W(8), .INSTR_W(16)) bus_b ();

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HLT_OP(5'h1F)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE), .HLT_OP(5'h1F)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_a.imem_rd_en) bus_a.imem_rdata <= mem_a[bus_a.imem_addr];
    if (bus_b.imem_rd_en) bus_b.imem_rdata <= mem_b[bus_b.imem_addr];
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus_a.stall_F = 1'b0; bus_a.flush_F = 1'b0; bus_a.branch_taken = 1'b0; bus_a.branch_target = 8'h00;
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus_a.stall_F = 1'b0; bus_a.flush_F = 1'b0; bus_a.branch_taken = 1'b0; bus_a.branch_target = 8'h00;
    rst = 1'b1;
    edges(1);
    n_tests++; if (bus_a.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", bus_a.imem_rd_en); end
    n_tests++; if (bus_a.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", bus_a.imem_addr); end
    n_tests++; if (bus_b.imem_addr !== 8'hFE) begin n_fail++; $display("FAIL reset_addr_b: got %h expected fe", bus_b.imem_addr); end
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== 25'h0) begin n_fail++; $display("FAIL reset_fd: got %b/%h/%h expected 0/00/0000", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus_a.imem_rd_en !== 1'b1) begin n_fail++; $display("FAIL reset_release_rd_en: got %b expected 1", bus_a.imem_rd_en); end
  endtask

  task automatic test_stream();
    do_reset();
    edges(1);
    n_tests++; if (bus_a.valid_D !== 1'b0) begin n_fail++; $display("FAIL stream_first_edge_valid: got %b expected 0", bus_a.valid_D); end
    edges(1);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'(i), 16'h0100 + 16'(i)}) begin
        n_fail++; $display("FAIL stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, bus_a.valid_D, bus_a.pc_D, bus_a.instr_D, 8'(i), 16'h0100 + 16'(i));
      end
      edges(1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    edges(6);
    n_tests++; if (bus_a.pc_D !== 8'h04) begin n_fail++; $display("FAIL stall_pre_pc: got %h expected 04", bus_a.pc_D); end
    bus_a.stall_F = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      n_tests++;
      if ({bus_a.valid_D, bus_a.pc_D, bus_a.imem_rd_en} !== {1'b1, 8'h04, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_%0d: got v=%b pc=%h rd_en=%b expected v=1 pc=04 rd_en=0", i, bus_a.valid_D, bus_a.pc_D, bus_a.imem_rd_en);
      end
    end
    bus_a.stall_F = 1'b0;
    edges(1);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'h05, 16'h0105}) begin n_fail++; $display("FAIL stall_release_skid: got v=%b pc=%h instr=%h expected 1/05/0105", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
    edges(1);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'h06, 16'h0106}) begin n_fail++; $display("FAIL stall_release_next: got v=%b pc=%h instr=%h expected 1/06/0106", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    edges(6);
    bus_a.stall_F = 1'b1;
    edges(1);
    bus_a.branch_taken = 1'b1; bus_a.flush_F = 1'b1; bus_a.branch_target = 8'h40;
    #1;
    n_tests++; if (bus_a.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL redirect_no_issue: got %b expected 0", bus_a.imem_rd_en); end
    edges(1);
    n_tests++; if ({bus_a.valid_D, bus_a.imem_addr} !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL redirect_bubble: got v=%b addr=%h expected v=0 addr=40", bus_a.valid_D, bus_a.imem_addr); end
    bus_a.branch_taken = 1'b0; bus_a.flush_F = 1'b0; bus_a.stall_F = 1'b0;
    edges(2);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'h40, 16'h0140}) begin n_fail++; $display("FAIL redirect_target: got v=%b pc=%h instr=%h expected 1/40/0140", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
    edges(1);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D} !== {1'b1, 8'h41}) begin n_fail++; $display("FAIL redirect_follow: got v=%b pc=%h expected 1/41", bus_a.valid_D, bus_a.pc_D); end
  endtask

  task automatic test_wrap();
    logic [7:0] p;
    do_reset();
    edges(2);
    for (int i = 0; i < 4; i++) begin
      p = 8'hFE + 8'(i);
      n_tests++;
      if ({bus_b.valid_D, bus_b.pc_D, bus_b.instr_D} !== {1'b1, p, 8'h01, p}) begin
        n_fail++; $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=01%h", i, bus_b.valid_D, bus_b.pc_D, bus_b.instr_D, p, p);
      end
      edges(1);
    end
  endtask

  task automatic test_halt();
    mem_a[3] = 16'hF800;
    do_reset();
    edges(5);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D, bus_a.imem_rd_en} !== {1'b1, 8'h03, 16'hF800, 1'b0}) begin n_fail++; $display("FAIL halt_entry: got v=%b pc=%h instr=%h rd_en=%b expected 1/03/f800/0", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D, bus_a.imem_rd_en); end
    for (int i = 0; i < 10; i++) begin
      edges(1);
      n_tests++;
      if ({bus_a.valid_D, bus_a.pc_D, bus_a.imem_rd_en} !== {1'b1, 8'h03, 1'b0}) begin
        n_fail++; $display("FAIL halt_frozen_%0d: got v=%b pc=%h rd_en=%b expected 1/03/0", i, bus_a.valid_D, bus_a.pc_D, bus_a.imem_rd_en);
      end
    end
    bus_a.branch_taken = 1'b1; bus_a.branch_target = 8'h10;
    edges(1);
    bus_a.branch_taken = 1'b0;
    edges(2);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'h10, 16'h0110}) begin n_fail++; $display("FAIL halt_exit: got v=%b pc=%h instr=%h expected 1/10/0110", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
    mem_a[3] = 16'h0103;
  endtask

  task automatic test_flush();
    do_reset();
    edges(8);
    n_tests++; if ({bus_a.imem_addr, bus_a.pc_D} !== {8'h08, 8'h06}) begin n_fail++; $display("FAIL flush_pre: got addr=%h pc=%h expected 08/06", bus_a.imem_addr, bus_a.pc_D); end
    bus_a.flush_F = 1'b1;
    edges(1);
    bus_a.flush_F = 1'b0;
    #1;
    n_tests++; if ({bus_a.valid_D, bus_a.imem_addr, bus_a.imem_rd_en} !== {1'b0, 8'h07, 1'b1}) begin n_fail++; $display("FAIL flush_rewind: got v=%b addr=%h rd_en=%b expected 0/07/1", bus_a.valid_D, bus_a.imem_addr, bus_a.imem_rd_en); end
    edges(2);
    n_tests++; if ({bus_a.valid_D, bus_a.pc_D, bus_a.instr_D} !== {1'b1, 8'h07, 16'h0107}) begin n_fail++; $display("FAIL flush_refetch: got v=%b pc=%h instr=%h expected 1/07/0107", bus_a.valid_D, bus_a.pc_D, bus_a.instr_D); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0100 + 16'(i);
      mem_b[i] = 16'h0100 + 16'(i);
    end
    bus_b.stall_F = 1'b0; bus_b.flush_F = 1'b0; bus_b.branch_taken = 1'b0; bus_b.branch_target = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_hold();
    test_wrap();
    test_halt();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
